// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: prefetching instruction fetch with redirect/flush and a decode-side queue.
// Optional pop counter output fetch_cnt enabled by IFU_FETCH_STATS_EN.
module instr_fetch_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9
) (
  input  logic              clk1,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
`ifdef IFU_FETCH_STATS_EN
  output logic [15:0]       fetch_cnt,
`endif
  output logic [ADDR_W-1:0] out_npc
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, flush_addr_q;
  logic [CW-1:0] count_q, count_nx;
  logic [PW-1:0] wp_q, rp_q;
  logic [DATA_W-1:0] ir_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] npc_q [FIFO_DEPTH];
  logic push, pop;
  assign pop = out_valid && out_ready;
  assign push = state_q == REQ && imem_ack && !redirect_valid;
  assign count_nx = count_q + CW'(push) - CW'(pop);
  assign pc_d = redirect_valid ? redirect_pc : push ? pc_q + ADDR_W'(1) : pc_q;
  always_ff @(posedge clk1)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (redirect_valid || count_q < CW'(FIFO_DEPTH)) ? REQ : IDLE;
      REQ:     state_d = redirect_valid ? (imem_ack ? REQ : FLUSH)
                       : imem_ack ? (count_nx < CW'(FIFO_DEPTH) ? REQ : IDLE) : REQ;
      FLUSH:   state_d = imem_ack ? REQ : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  // The stale request keeps its address in FLUSH while pc already tracks the redirect target.
  always_comb begin
    imem_req  = !rst && state_q != IDLE;
    imem_addr = state_q == FLUSH ? flush_addr_q : pc_q;
    out_valid = !rst && count_q != '0;
    out_ir    = out_valid ? ir_q[rp_q] : '0;
    out_npc   = out_valid ? npc_q[rp_q] : '0;
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_q    <= '0;
      count_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      pc_q <= pc_d;
      if (state_q != FLUSH) flush_addr_q <= pc_q;
      if (redirect_valid) begin
        count_q <= '0;
        wp_q    <= '0;
        rp_q    <= '0;
      end else begin
        count_q <= count_nx;
        if (push) wp_q <= wp_q + PW'(1);
        if (pop) rp_q <= rp_q + PW'(1);
      end
    end
  end
  always_ff @(posedge clk1)
    if (push) begin
      ir_q[wp_q]  <= imem_rdata;
      npc_q[wp_q] <= pc_q + ADDR_W'(1);
    end
`ifdef IFU_FETCH_STATS_EN
  logic [15:0] fetch_cnt_q;
  always_ff @(posedge clk1)
    if (rst) fetch_cnt_q <= '0;
    else if (pop && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
  assign fetch_cnt = fetch_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench; stimulus queues expected pops, a negedge monitor checks them.
module tb_instr_fetch_unit;
  logic clk1 = 0, rst = 1;
  logic imem_req, imem_ack, redirect_valid = 0, out_valid, out_ready = 0;
  logic [9:0] imem_addr, redirect_pc = '0, out_npc;
  logic [8:0] imem_rdata, out_ir;
`ifdef IFU_FETCH_STATS_EN
  logic [15:0] fetch_cnt;
`endif
  logic [8:0] mem [1024];
  int ack_delay = 0, wait_cnt = 0, pop_cnt = 0, tests = 0, fails = 0;
  logic [18:0] sb [$];
  logic [9:0] ack_log [$];
  logic pend_q = 0;
  logic [9:0] pend_addr = '0;

  instr_fetch_unit dut (
    .clk1(clk1), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir),
`ifdef IFU_FETCH_STATS_EN
    .fetch_cnt(fetch_cnt),
`endif
    .out_npc(out_npc));

  always #5 clk1 = ~clk1;
  assign imem_ack = imem_req && wait_cnt >= ack_delay;
  assign imem_rdata = mem[imem_addr];

  always @(posedge clk1)
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk1) begin
    logic [18:0] e;
    if (out_valid && out_ready) begin
      pop_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got ir=0x%0h npc=%0d expected no pop", out_ir, out_npc);
      end else begin
        e = sb.pop_front();
        check("out_ir", int'(out_ir), int'(e[18:10]));
        check("out_npc", int'(out_npc), int'(e[9:0]));
      end
    end
    if (imem_req && imem_ack) ack_log.push_back(imem_addr);
    if (pend_q && imem_req) check("addr_stable", int'(imem_addr), int'(pend_addr));
    pend_q = imem_req && !imem_ack;
    pend_addr = imem_addr;
  end

  task automatic expect_pop(input logic [8:0] ir, input logic [9:0] npc);
    sb.push_back({ir, npc});
  endtask

  task automatic wait_pops(input int n);
    int tgt = pop_cnt + n;
    int k = 0;
    out_ready = 1;
    while (pop_cnt < tgt && k < 200) begin
      @(posedge clk1);
      k++;
    end
    if (pop_cnt < tgt) check("pop_timeout", pop_cnt, tgt);
    #1 out_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    out_ready = 0;
    redirect_valid = 0;
    repeat (2) @(posedge clk1);
    #1;
    check("rst_imem_req", int'(imem_req), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_ir", int'(out_ir), 0);
    check("rst_out_npc", int'(out_npc), 0);
    check("sb_drained", sb.size(), 0);
    sb.delete();
    ack_log.delete();
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[i]) mem[i] = '0;
    mem[0] = 9'h041; mem[1] = 9'h0C2; mem[2] = 9'h103; mem[3] = 9'h144;
    mem[4] = 9'h185; mem[200] = 9'h0C8; mem[201] = 9'h1C9; mem[1023] = 9'h1FF;
    // Reset release latency, then in-order stream
    do_reset();
    @(posedge clk1); #1;
    check("valid_after_1", int'(out_valid), 0);
    @(posedge clk1); #1;
    check("valid_after_2", int'(out_valid), 1);
    expect_pop(9'h041, 10'd1); expect_pop(9'h0C2, 10'd2);
    expect_pop(9'h103, 10'd3); expect_pop(9'h144, 10'd4);
    wait_pops(4);
    // Backpressure fills the queue, one pop allows exactly one more fetch
    do_reset();
    repeat (12) @(posedge clk1);
    #1;
    check("full_valid", int'(out_valid), 1);
    check("full_req", int'(imem_req), 0);
    check("full_fetches", ack_log.size(), 4);
    expect_pop(9'h041, 10'd1);
    wait_pops(1);
    repeat (6) @(posedge clk1);
    #1;
    check("refill_fetches", ack_log.size(), 5);
    if (ack_log.size() == 5) check("refill_addr", int'(ack_log[4]), 4);
    check("refill_req", int'(imem_req), 0);
    expect_pop(9'h0C2, 10'd2); expect_pop(9'h103, 10'd3);
    expect_pop(9'h144, 10'd4); expect_pop(9'h185, 10'd5);
    wait_pops(4);
    // Redirect while a slow request is outstanding
    ack_delay = 3;
    do_reset();
    @(posedge clk1); #1;
    check("slow_req", int'(imem_req), 1);
    redirect_valid = 1;
    redirect_pc = 10'd200;
    @(posedge clk1); #1;
    redirect_valid = 0;
    check("flush_req", int'(imem_req), 1);
    check("flush_addr", int'(imem_addr), 0);
    expect_pop(9'h0C8, 10'd201); expect_pop(9'h1C9, 10'd202);
    repeat (12) @(posedge clk1);
    #1;
    wait_pops(2);
    check("redir_acks", int'(ack_log.size() >= 2), 1);
    if (ack_log.size() >= 2) begin
      check("stale_addr", int'(ack_log[0]), 0);
      check("redir_addr", int'(ack_log[1]), 200);
    end
    // Address wrap at 1023
    ack_delay = 0;
    do_reset();
    redirect_valid = 1;
    redirect_pc = 10'd1023;
    @(posedge clk1); #1;
    redirect_valid = 0;
    expect_pop(9'h1FF, 10'd0); expect_pop(9'h041, 10'd1);
    repeat (4) @(posedge clk1);
    #1;
    wait_pops(2);
    check("wrap_acks", int'(ack_log.size() >= 2), 1);
    if (ack_log.size() >= 2) begin
      check("wrap_addr0", int'(ack_log[0]), 1023);
      check("wrap_addr1", int'(ack_log[1]), 0);
    end
`ifdef IFU_FETCH_STATS_EN
    check("fetch_cnt", int'(fetch_cnt), 2);
`endif
    // Reset during an acknowledged request
    do_reset();
    @(posedge clk1); #1;
    check("pre_rst_handshake", int'(imem_req && imem_ack), 1);
    rst = 1;
    @(posedge clk1); #1;
    rst = 0;
    #1;
    check("post_rst_req", int'(imem_req), 0);
    check("post_rst_valid", int'(out_valid), 0);
    ack_log.delete();
    expect_pop(9'h041, 10'd1);
    repeat (3) @(posedge clk1);
    #1;
    wait_pops(1);
    check("restart_acks", int'(ack_log.size() >= 1), 1);
    if (ack_log.size() >= 1) check("restart_addr", int'(ack_log[0]), 0);
    do_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
